spi_word_controller: RTL and testbench

SPI controller (host end) that drives the 64-bit word protocol used by the stepper SPI peripheral. It accepts a 64-bit word on a start/busy/done handshake and shifts it out on COPI while simultaneously capturing 64 bits from CIPO. The block serves two purposes: on-chip host emulation for verification benches, and a daisy-chained controller that lets one core command a second motion core.
- Framing: SPI mode 0 (CPOL=0, CPHA=0), one word per CS frame.
- Byte order: little-endian, so byte 0 (bits 7:0) is sent first.
- Bit order: MSB-first within each byte.

---
 rtl/spi_word_controller.sv | 173 +++++++++++++++++
 tb/tb_spi_word_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spi_word_controller.sv
// SPI mode-0 host controller: shifts one word out on COPI while capturing CIPO, one word per CS frame.
// Byte 0 goes first and each byte is sent MSB-first; start/busy/done handshake, start ignored while busy.
module spi_word_controller #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 64
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] word_tx,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] word_rx,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);
    localparam int            IW       = $clog2(WORD_BITS);
    localparam int            CW       = IW + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_word_controller: CLK_DIV must be within 1..255");
    end
    if (WORD_BITS < 8 || (WORD_BITS % 8) != 0) begin : g_bad_width
        $error("spi_word_controller: WORD_BITS must be a non-zero multiple of 8");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic [CW-1:0]        bit_nxt;
    logic [WORD_BITS-1:0] tx_q, tx_d;
    logic [WORD_BITS-1:0] rx_q, rx_d;
    logic [WORD_BITS-1:0] word_rx_q, word_rx_d;
    logic                 sck_q, sck_d;
    logic                 cs_q, cs_d;
    logic                 copi_q, copi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;

    // Wire bit n lives at word index 8*(n/8) + 7 - n%8, i.e. n with its low three bits inverted.
    function automatic logic [IW-1:0] wire_idx(input logic [CW-1:0] n);
        return n[IW-1:0] ^ IW'(7);
    endfunction

    assign tick    = (div_q == DIV_LAST);
    assign bit_nxt = bit_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = 8'd0;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        word_rx_d = word_rx_q;
        sck_d     = sck_q;
        cs_d      = cs_q;
        copi_d    = copi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != IDLE && !tick) begin
            div_d = div_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = word_tx;
                    rx_d    = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    copi_d  = word_tx[wire_idx('0)];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_d                 = 1'b1;
                    rx_d[wire_idx(bit_q)] = CIPO;
                    state_d               = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    sck_d   = 1'b0;
                    copi_d  = (bit_q == LAST_BIT) ? 1'b0 : tx_q[wire_idx(bit_nxt)];
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_d                   = bit_nxt;
                        sck_d                   = 1'b1;
                        rx_d[wire_idx(bit_nxt)] = CIPO;
                        state_d                 = SHIFT_HI;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    word_rx_d = rx_q;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    bit_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            word_rx_q <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            word_rx_q <= word_rx_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            copi_q    <= copi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign word_rx = word_rx_q;
    assign SCK     = sck_q;
    assign CS      = cs_q;
    assign COPI    = copi_q;

endmodule

// File: tb/tb_spi_word_controller.sv
// Bench for spi_word_controller: CLK_DIV=2 instance with loopback or model peripheral, CLK_DIV=1 instance for back-to-back frames.
module tb_spi_word_controller;
    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        resetn;
    logic        start_a, busy_a, done_a, sck_a, cs_a, copi_a, cipo_a;
    logic [63:0] word_tx_a, word_rx_a;
    logic        start_b, busy_b, done_b, sck_b, cs_b, copi_b;
    logic [63:0] word_tx_b, word_rx_b;

    spi_word_controller #(.CLK_DIV(DIV_A), .WORD_BITS(64)) u_dut_a (
        .CLK(CLK), .resetn(resetn), .start(start_a), .word_tx(word_tx_a),
        .busy(busy_a), .done(done_a), .word_rx(word_rx_a),
        .SCK(sck_a), .CS(cs_a), .COPI(copi_a), .CIPO(cipo_a)
    );

    spi_word_controller #(.CLK_DIV(DIV_B), .WORD_BITS(64)) u_dut_b (
        .CLK(CLK), .resetn(resetn), .start(start_b), .word_tx(word_tx_b),
        .busy(busy_b), .done(done_b), .word_rx(word_rx_b),
        .SCK(sck_b), .CS(cs_b), .COPI(copi_b), .CIPO(copi_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int map_bit(input int n);
        return 8 * (n / 8) + 7 - (n % 8);
    endfunction

    // Model peripheral: mode 0, presents bit 0 when CS falls and the next bit after each SCK fall.
    logic        loop_a   = 1'b1;
    logic [63:0] per_word = '0;
    int          fall_cnt_a = 0;
    logic        per_bit;
    always_comb begin
        per_bit = 1'b0;
        if (!cs_a && fall_cnt_a < 64) per_bit = per_word[map_bit(fall_cnt_a)];
    end
    assign cipo_a = loop_a ? copi_a : per_bit;

    int   cyc = 0;
    int   rise_cnt_a = 0, done_cnt_a = 0, done_cyc_a = -1, busy_fall_cyc_a = -1;
    int   last_rise_a = -1, last_fall_a = -1, width_err_a = 0;
    bit   copi_hi_a = 1'b0;
    logic copi_smp_a[$];
    logic cs_prev_a = 1'b1, sck_prev_a = 1'b0, busy_prev_a = 1'b0;
    int   done_b_q[$];
    int   cs_rise_b = -1, cs_gap_b = -1;
    logic cs_prev_b = 1'b1;

    always @(posedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (cs_prev_a && !cs_a) begin
            rise_cnt_a = 0; fall_cnt_a = 0; copi_hi_a = 1'b0;
            copi_smp_a.delete(); last_rise_a = -1; last_fall_a = -1;
        end
        if (!cs_a && copi_a) copi_hi_a = 1'b1;
        if (!sck_prev_a && sck_a) begin
            rise_cnt_a++;
            copi_smp_a.push_back(copi_a);
            if (resetn && last_fall_a >= 0 && cyc - last_fall_a != DIV_A) width_err_a++;
            last_rise_a = cyc;
        end
        if (sck_prev_a && !sck_a) begin
            if (!cs_a) fall_cnt_a++;
            if (resetn && cyc - last_rise_a != DIV_A) width_err_a++;
            last_fall_a = cyc;
        end
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (busy_prev_a && !busy_a) busy_fall_cyc_a = cyc;
        if (done_b) done_b_q.push_back(cyc);
        if (!cs_prev_b && cs_b) cs_rise_b = cyc;
        if (cs_prev_b && !cs_b && cs_rise_b >= 0) cs_gap_b = cyc - cs_rise_b;
        cs_prev_a = cs_a; sck_prev_a = sck_a; busy_prev_a = busy_a; cs_prev_b = cs_b;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic frame_a(input string tag, input logic [63:0] w, input bit lb,
                           input logic [63:0] pw, input bit repulse);
        int          acc, t, d0;
        logic [63:0] recon, exp_rx;
        logic [7:0]  b0;
        loop_a = lb; per_word = pw; d0 = done_cnt_a;
        exp_rx = lb ? w : pw;
        word_tx_a = w; start_a = 1'b1;
        tick(1);
        acc = cyc; start_a = 1'b0; word_tx_a = {$urandom, $urandom};
        t = 0;
        while (done_cnt_a == d0 && t < 400) begin
            tick(1); t++;
            if (repulse && t == 50) begin start_a = 1'b1; word_tx_a = '1; end
            if (repulse && t == 60) start_a = 1'b0;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt_a - d0), 64'd1);
        chk({tag, "_done_lat"}, 64'(done_cyc_a - acc), 64'(130 * DIV_A));
        chk({tag, "_word_rx"}, word_rx_a, exp_rx);
        t = 0;
        while (busy_a && t < 50) begin tick(1); t++; end
        chk({tag, "_busy_fall"}, 64'(busy_fall_cyc_a - acc), 64'(131 * DIV_A));
        tick(20);
        chk({tag, "_one_done"}, 64'(done_cnt_a - d0), 64'd1);
        chk({tag, "_idle_after"}, {62'd0, busy_a, cs_a}, 64'd1);
        chk({tag, "_rx_hold"}, word_rx_a, exp_rx);
        chk({tag, "_rises"}, 64'(rise_cnt_a), 64'd64);
        chk({tag, "_sck_width_err"}, 64'(width_err_a), 64'd0);
        recon = '0; b0 = '0;
        for (int n = 0; n < 64 && n < copi_smp_a.size(); n++) recon[map_bit(n)] = copi_smp_a[n];
        for (int n = 0; n < 8 && n < copi_smp_a.size(); n++) b0[7 - n] = copi_smp_a[n];
        chk({tag, "_copi_word"}, recon, w);
        chk({tag, "_copi_byte0"}, 64'(b0), 64'(w[7:0]));
        if (w == 64'd0) chk({tag, "_copi_quiet"}, 64'(copi_hi_a), 64'd0);
    endtask

    initial begin
        int          t, d0, bad;
        logic [63:0] w;
        resetn = 1'b0; start_a = 1'b0; start_b = 1'b0;
        word_tx_a = '0; word_tx_b = '0;
        tick(3);
        chk("reset_outputs", {59'd0, cs_a, sck_a, copi_a, busy_a, done_a}, 64'b10000);
        chk("reset_word_rx", word_rx_a, 64'd0);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if ({cs_a, sck_a, busy_a, done_a} !== 4'b1000 || word_rx_a !== 64'd0) bad++;
        end
        chk("idle_100_bad_cycles", 64'(bad), 64'd0);

        frame_a("loopback", 64'h0123456789ABCDEF, 1'b1, 64'd0, 1'b0);
        frame_a("periph_deadbeef", 64'd0, 1'b0, 64'h00000000DEADBEEF, 1'b0);
        frame_a("repulse", {$urandom, $urandom}, 1'b1, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++)
            frame_a($sformatf("rand%0d", i), {$urandom, $urandom}, 1'b0, {$urandom, $urandom}, 1'b0);

        // Back-to-back frames with start held high on the CLK_DIV=1 instance.
        w = {$urandom, $urandom};
        word_tx_b = w; start_b = 1'b1;
        t = 0;
        while (done_b_q.size() < 2 && t < 600) begin tick(1); t++; end
        start_b = 1'b0;
        chk("b2b_two_dones", 64'(done_b_q.size()), 64'd2);
        if (done_b_q.size() >= 2) chk("b2b_spacing", 64'(done_b_q[1] - done_b_q[0]), 64'd132);
        chk("b2b_word_rx", word_rx_b, w);
        chk("b2b_cs_gap_ge1", 64'(cs_gap_b >= 1), 64'd1);
        tick(10);

        // Reset one cycle after the 20th SCK rise.
        loop_a = 1'b1; d0 = done_cnt_a;
        word_tx_a = {$urandom, $urandom}; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        t = 0;
        while (rise_cnt_a < 20 && t < 200) begin tick(1); t++; end
        chk("rst_mid_reached_20_rises", 64'(rise_cnt_a), 64'd20);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        chk("rst_mid_cs_sck", {62'd0, cs_a, sck_a}, 64'b10);
        chk("rst_mid_busy", 64'(busy_a), 64'd0);
        chk("rst_mid_word_rx", word_rx_a, 64'd0);
        tick(300);
        chk("rst_mid_no_done", 64'(done_cnt_a - d0), 64'd0);
        frame_a("after_reset", {$urandom, $urandom}, 1'b1, 64'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
